sram_frame_buffer_arbiter: RTL and testbench

//  Shares the single off-chip async SRAM frame buffer between two requesters:
//  the display read path (pixel fetch, high priority) and the draw/write path
//  (video cores writing pixels). It sequences every SRAM access (setup, strobe,

---
 rtl/sram_frame_buffer_arbiter_if.sv | 27 ++
 rtl/sram_frame_buffer_arbiter.sv | 98 +++++++++
 tb/tb_sram_frame_buffer_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_frame_buffer_arbiter_if.sv
// Requester-side bus of the frame buffer arbiter: display read port, draw write port, busy.
interface sram_frame_buffer_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic              rd_rvalid;
  logic [DATA_W-1:0] rd_rdata;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        wr_be;
  logic              wr_ready;
  logic              busy;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_ready, rd_rvalid, rd_rdata, wr_ready, busy
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_ready, rd_rvalid, rd_rdata, wr_ready, busy
  );
endinterface

// File: rtl/sram_frame_buffer_arbiter.sv
// Shares one async SRAM between the display read path (priority) and the draw write path,
// sequencing setup/strobe/turnaround and driving the SRAM pins.
module sram_frame_buffer_arbiter #(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int SRAM_CYCLES  = 2,
  parameter int MAX_RD_BURST = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  sram_frame_buffer_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]      sram_addr,
  inout  wire  [DATA_W-1:0]      sram_dq,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic [1:0]             sram_be_n
);
  localparam int CW = $clog2(SRAM_CYCLES);
  localparam int SW = $clog2(MAX_RD_BURST + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_TURN  = 2'd3;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        be;
  logic [SW-1:0]     rd_streak;
  logic              idle, wr_win, last, dq_oe;

  assign idle = (state == S_IDLE);
  assign last = (cnt == CW'(SRAM_CYCLES - 1));

  // A pending write only beats a read once the read streak has saturated.
  assign wr_win       = bus.wr_req & (~bus.rd_req | (rd_streak == SW'(MAX_RD_BURST)));
  assign bus.wr_ready = idle & ~sys_rst & wr_win;
  assign bus.rd_ready = idle & ~sys_rst & bus.rd_req & ~wr_win;
  assign bus.busy     = ~idle;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      sram_addr     <= '0;
      wdata         <= '0;
      be            <= '0;
      rd_streak     <= '0;
      bus.rd_rvalid <= 1'b0;
      bus.rd_rdata  <= '0;
    end else begin
      bus.rd_rvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.wr_ready) begin
            state     <= S_WRITE;
            cnt       <= '0;
            sram_addr <= bus.wr_addr;
            wdata     <= bus.wr_data;
            be        <= bus.wr_be;
            rd_streak <= '0;
          end else if (bus.rd_ready) begin
            state     <= S_READ;
            cnt       <= '0;
            sram_addr <= bus.rd_addr;
            if (rd_streak != SW'(MAX_RD_BURST)) rd_streak <= rd_streak + SW'(1);
          end
        end
        S_READ: begin
          if (last) begin
            bus.rd_rdata  <= sram_dq;
            bus.rd_rvalid <= 1'b1;
            state         <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WRITE: begin
          if (last) state <= S_TURN;
          else      cnt   <= cnt + CW'(1);
        end
        S_TURN:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // First WRITE cycle is address setup; the strobe covers the rest, TURN holds data.
  assign sram_ce_n = ~((state == S_READ) | (state == S_WRITE));
  assign sram_oe_n = ~(state == S_READ);
  assign sram_we_n = ~((state == S_WRITE) & (cnt != '0));
  assign sram_be_n = (state == S_READ)  ? 2'b00 :
                     (state == S_WRITE) ? ~be   : 2'b11;
  assign dq_oe     = (state == S_WRITE) | (state == S_TURN);
  assign sram_dq   = dq_oe ? wdata : {DATA_W{1'bz}};
endmodule

// File: tb/tb_sram_frame_buffer_arbiter.sv
// Bench for the SRAM frame buffer arbiter: SRAM behavioural model, read scoreboard, grant log.
module tb_sram_frame_buffer_arbiter;
  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  sram_frame_buffer_arbiter_if #(.ADDR_W(18), .DATA_W(16)) bus();

  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        ce_n, oe_n, we_n;
  logic [1:0]  be_n;

  sram_frame_buffer_arbiter #(
    .ADDR_W(18), .DATA_W(16), .SRAM_CYCLES(2), .MAX_RD_BURST(8)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus),
    .sram_addr(sram_addr), .sram_dq(sram_dq), .sram_ce_n(ce_n),
    .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_be_n(be_n)
  );

  // SRAM model, decoded on the low 8 address bits
  logic [15:0] mem [0:255];
  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;
  logic [15:0] model_q;
  assign model_q = mem[sram_addr[7:0]];
  assign sram_dq = (!ce_n && !oe_n) ? model_q : 16'hzzzz;

  always @(posedge sys_clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (!ce_n && !we_n) begin
      if (!be_n[0]) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      if (!be_n[1]) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
    end
  end

  typedef struct { logic [15:0] data; int cyc; } exp_t;
  exp_t sb[$];
  byte  grants[$];
  int   checks = 0, errors = 0, cyc = 0, rvalid_cnt = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (sys_rst) sb.delete();
    else begin
      checks++;
      if (bus.rd_ready && bus.wr_ready) begin
        errors++; $display("FAIL ready_exclusive: rd_ready=1 wr_ready=1, required at most one");
      end
      if (!oe_n) begin
        checks++;
        if (sram_dq !== model_q) begin
          errors++; $display("FAIL dq_contention: dq=%h, required sram value %h", sram_dq, model_q);
        end
      end
      if (bus.rd_req && bus.rd_ready) begin
        sb.push_back('{mem[bus.rd_addr[7:0]], cyc + 3});
        grants.push_back("R");
      end
      if (bus.wr_req && bus.wr_ready) grants.push_back("W");
      if (bus.rd_rvalid) begin
        exp_t e;
        rvalid_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rvalid_unexpected: rd_rvalid at cycle %0d with nothing outstanding", cyc);
        end else begin
          e = sb.pop_front();
          if (bus.rd_rdata !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL read_scoreboard: data=%h cycle=%0d, required data=%h cycle=%0d",
                     bus.rd_rdata, cyc, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic rst_pulse();
    sys_rst = 1'b1; tick(); sys_rst = 1'b0; tick();
  endtask

  task automatic wait_grants(input int n, input int budget, input string tag);
    int k = 0;
    while (grants.size() < n && k < budget) begin tick(); k++; end
    checks++;
    if (grants.size() < n) begin
      errors++; $display("FAIL %s: %0d grants after %0d cycles, required %0d", tag, grants.size(), k, n);
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || bus.busy) && k < 100) begin tick(); k++; end
    checks++;
    if (k >= 100) begin
      errors++; $display("FAIL drain_timeout: %0d reads outstanding, busy=%b", sb.size(), bus.busy);
    end
  endtask

  task automatic do_read(input logic [17:0] a);
    bus.rd_addr = a; bus.rd_req = 1'b1;
    wait_grants(grants.size() + 1, 50, "rd_accept");
    bus.rd_req = 1'b0;
  endtask

  task automatic test_reset();
    bus.rd_req = 1'b1; bus.wr_req = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.rd_ready, bus.wr_ready, bus.rd_rvalid, bus.busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_handshake: %b, required 0000",
                         {bus.rd_ready, bus.wr_ready, bus.rd_rvalid, bus.busy});
    end
    checks++;
    if (bus.rd_rdata !== 16'h0) begin
      errors++; $display("FAIL reset_rdata: %h, required 0000", bus.rd_rdata);
    end
    checks++;
    if (sram_addr !== 18'h0) begin
      errors++; $display("FAIL reset_addr: %h, required 00000", sram_addr);
    end
    checks++;
    if ({ce_n, oe_n, we_n, be_n} !== 5'b11111) begin
      errors++; $display("FAIL reset_strobes: %b, required 11111", {ce_n, oe_n, we_n, be_n});
    end
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    sys_rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    preload(8'h10, 16'hA5C3);
    do_read(18'h00010);
    drain();
    checks++;
    if (bus.rd_rdata !== 16'hA5C3) begin
      errors++; $display("FAIL single_read: rdata=%h, required a5c3", bus.rd_rdata);
    end
  endtask

  task automatic test_write();
    int we_low = 0, drv = 0;
    logic [1:0] be_seen = 2'bxx;
    preload(8'hFF, 16'hBEEF);
    bus.wr_addr = 18'h3FFFF; bus.wr_data = 16'h1234; bus.wr_be = 2'b01; bus.wr_req = 1'b1;
    wait_grants(grants.size() + 1, 50, "wr_accept");
    bus.wr_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      if (!we_n) begin we_low++; be_seen = be_n; end
      if (sram_dq === 16'h1234) drv++;
    end
    checks++;
    if (we_low != 1) begin
      errors++; $display("FAIL write_we_width: we_n low %0d cycles, required 1", we_low);
    end
    checks++;
    if (drv != 3) begin
      errors++; $display("FAIL write_dq_cycles: dq driven %0d cycles, required 3", drv);
    end
    checks++;
    if (be_seen !== 2'b10) begin
      errors++; $display("FAIL write_be_n: %b, required 10", be_seen);
    end
    checks++;
    if (sram_addr !== 18'h3FFFF) begin
      errors++; $display("FAIL write_addr: %h, required 3ffff", sram_addr);
    end
    tick();
    do_read(18'h3FFFF);
    drain();
    checks++;
    if (bus.rd_rdata !== 16'hBE34) begin
      errors++; $display("FAIL write_readback: rdata=%h, required be34", bus.rd_rdata);
    end
  endtask

  task automatic test_read_streak();
    byte expc;
    rst_pulse();
    preload(8'h30, 16'h3030);
    grants.delete();
    bus.rd_addr = 18'h00030; bus.rd_req = 1'b1;
    bus.wr_addr = 18'h00020; bus.wr_data = 16'h5555; bus.wr_be = 2'b11; bus.wr_req = 1'b1;
    wait_grants(18, 400, "streak_grants");
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    drain();
    for (int i = 0; i < 18 && i < grants.size(); i++) begin
      expc = (i == 8 || i == 17) ? "W" : "R";
      checks++;
      if (grants[i] !== expc) begin
        errors++; $display("FAIL streak_order[%0d]: grant %c, required %c", i, grants[i], expc);
      end
    end
  endtask

  task automatic test_simultaneous();
    rst_pulse();
    preload(8'h40, 16'h4040);
    grants.delete();
    bus.rd_addr = 18'h00040; bus.rd_req = 1'b1;
    bus.wr_addr = 18'h00041; bus.wr_data = 16'h0BAD; bus.wr_be = 2'b11; bus.wr_req = 1'b1;
    wait_grants(1, 50, "simul_first");
    bus.rd_req = 1'b0;
    wait_grants(2, 50, "simul_second");
    bus.wr_req = 1'b0;
    drain();
    checks++;
    if (grants.size() < 2 || grants[0] !== "R" || grants[1] !== "W") begin
      errors++; $display("FAIL simul_priority: %0d grants first=%c, required R then W",
                         grants.size(), (grants.size() > 0) ? grants[0] : "-");
    end
  endtask

  task automatic test_reset_mid_read();
    int rv0 = rvalid_cnt;
    do_read(18'h00010);
    tick();
    sys_rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, ce_n, oe_n, we_n, be_n} !== 6'b011111 || bus.rd_rdata !== 16'h0) begin
      errors++; $display("FAIL reset_mid_read: busy/strobes=%b rdata=%h, required 011111 0000",
                         {bus.busy, ce_n, oe_n, we_n, be_n}, bus.rd_rdata);
    end
    tick(); tick();
    sys_rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (rvalid_cnt != rv0) begin
      errors++; $display("FAIL reset_abort_rvalid: %0d pulses, required 0", rvalid_cnt - rv0);
    end
    do_read(18'h00010);
    drain();
    checks++;
    if (rvalid_cnt != rv0 + 1 || bus.rd_rdata !== 16'hA5C3) begin
      errors++; $display("FAIL read_after_reset: pulses=%0d rdata=%h, required 1 a5c3",
                         rvalid_cnt - rv0, bus.rd_rdata);
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
    test_reset();
    test_single_read();
    test_write();
    test_read_streak();
    test_simultaneous();
    test_reset_mid_read();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL final_outstanding: %0d reads, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
